uart_tx_mmio: RTL and testbench

//  Memory-mapped UART transmitter on the riscv64 core's data bus (bus_address/bus_write_data/...).

---
 rtl/uart_tx_mmio.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus stores queue bytes in a TX FIFO,
// a shift FSM serialises them, and STATUS/CTRL plus a level TX-empty irq are exposed.
module uart_tx_mmio #(
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BAUD       = 115_200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bus_address,
  input  logic [63:0] bus_write_data,
  input  logic        bus_write_enable,
  input  logic        bus_read_enable,
  output logic [63:0] bus_read_data,
  output logic        uart_txd,
  output logic        tx_irq
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          overflow, irq_en;

  logic        hit, wr_hit, rd_hit;
  logic [1:0]  sel;
  logic        empty, full, busy, baud_end;
  logic        pop, push_req, push, drop;
  logic [63:0] status_word, rd_mux;

  logic unused_bits;
  assign unused_bits = ^{bus_write_data[63:8], bus_address[2:0]};

  assign hit    = (bus_address[63:5] == BASE_ADDR[63:5]);
  assign sel    = bus_address[4:3];
  assign wr_hit = bus_write_enable & hit;
  assign rd_hit = bus_read_enable & hit;

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign busy     = (state != ST_IDLE);
  assign baud_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));

  // The stop-bit end edge may load the next byte directly, so frames abut.
  assign pop      = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & baud_end));
  assign push_req = wr_hit & (sel == 2'd0);
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign tx_irq = irq_en & empty & ~busy;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus_write_data[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      uart_txd <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shift    <= mem[rd_ptr];
            uart_txd <= 1'b0;
            baud_cnt <= '0;
            state    <= ST_START;
          end else begin
            uart_txd <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_txd <= shift[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= ST_STOP;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              shift    <= shift >> 1;
              uart_txd <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift    <= mem[rd_ptr];
              uart_txd <= 1'b0;
              state    <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    status_word          = '0;
    status_word[0]       = full;
    status_word[1]       = empty;
    status_word[2]       = busy;
    status_word[3]       = overflow;
    status_word[8 +: CW] = count;
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      2'd1:    rd_mux = status_word;
      2'd2:    rd_mux[0] = irq_en;
      default: rd_mux = '0;
    endcase
  end

  // Same-edge read and write: the mux sees pre-edge register values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_read_data <= '0;
      overflow      <= 1'b0;
      irq_en        <= 1'b0;
    end else begin
      if (rd_hit) bus_read_data <= rd_mux;
      if (drop) overflow <= 1'b1;
      else if (wr_hit && sel == 2'd1 && bus_write_data[3]) overflow <= 1'b0;
      if (wr_hit && sel == 2'd2) irq_en <= bus_write_data[0];
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register-map vector table plus frame,
// FIFO-overflow, interrupt and mid-frame-reset sequences at 10 clk/bit, 4-deep FIFO.
module tb_uart_tx_mmio;
  localparam logic [63:0] A_TX   = 64'h8000_0000;
  localparam logic [63:0] A_ST   = 64'h8000_0008;
  localparam logic [63:0] A_CTRL = 64'h8000_0010;
  localparam logic [63:0] A_RSV  = 64'h8000_0018;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] bus_address = '0;
  logic [63:0] bus_write_data = '0;
  logic        bus_write_enable = 1'b0;
  logic        bus_read_enable = 1'b0;
  logic [63:0] bus_read_data;
  logic        uart_txd;
  logic        tx_irq;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_mmio #(.CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4),
                 .BASE_ADDR(64'h8000_0000)) dut (
    .clk(clk), .reset(reset), .bus_address(bus_address),
    .bus_write_data(bus_write_data), .bus_write_enable(bus_write_enable),
    .bus_read_enable(bus_read_enable), .bus_read_data(bus_read_data),
    .uart_txd(uart_txd), .tx_irq(tx_irq));

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    bit          wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] exp;
  } op_t;

  op_t ops[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Consecutive-cycle stores; returns on the negedge after the last store edge.
  task automatic bus_burst(input logic [63:0] addr, input logic [7:0] b[6], input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus_address = addr; bus_write_data = {56'b0, b[i]}; bus_write_enable = 1'b1;
    end
    @(negedge clk);
    bus_write_enable = 1'b0;
  endtask

  task automatic bus_wr(input logic [63:0] addr, input logic [63:0] data);
    @(negedge clk);
    bus_address = addr; bus_write_data = data; bus_write_enable = 1'b1;
    @(negedge clk);
    bus_write_enable = 1'b0;
  endtask

  task automatic bus_rw(input logic [63:0] addr, input logic [63:0] data, input bit wr,
                        output logic [63:0] rd);
    @(negedge clk);
    bus_address = addr; bus_write_data = data;
    bus_write_enable = wr; bus_read_enable = 1'b1;
    @(negedge clk);
    bus_write_enable = 1'b0; bus_read_enable = 1'b0;
    rd = bus_read_data;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  // x counts negedges after the pop edge (one edge after the first store).
  task automatic chk_frames(input logic [23:0] bytes, input int nb, input int x0, input string nm);
    logic [7:0] b;
    for (int x = x0 + 1; x < nb * 100; x++) begin
      @(negedge clk);
      if ((x % 10) == 0 || (x % 10) == 5 || (x % 10) == 9) begin
        b = bytes[(x / 100) * 8 +: 8];
        check($sformatf("%s txd x=%0d", nm, x), {63'b0, uart_txd},
              {63'b0, frame_bit(b, (x % 100) / 10)});
      end
    end
  endtask

  initial begin
    logic [63:0] rd;
    logic [7:0]  bl[6];

    ops[0]  = '{"st_reset",    1'b0, A_ST,                 64'h0,    64'h2};
    ops[1]  = '{"ctrl_reset",  1'b0, A_CTRL,               64'h0,    64'h0};
    ops[2]  = '{"ctrl_wr1",    1'b1, A_CTRL,               64'h1,    64'h0};
    ops[3]  = '{"ctrl_rd1",    1'b0, A_CTRL,               64'h0,    64'h1};
    ops[4]  = '{"miss_hold",   1'b0, 64'h9000_0008,        64'h0,    64'h1};
    ops[5]  = '{"txdata_rd0",  1'b0, A_TX,                 64'h0,    64'h0};
    ops[6]  = '{"ctrl_alias",  1'b0, 64'h8000_0014,        64'h0,    64'h1};
    ops[7]  = '{"rsv_rd0",     1'b0, A_RSV,                64'h0,    64'h0};
    ops[8]  = '{"miss_wr",     1'b1, 64'h9000_0000,        64'h41,   64'h0};
    ops[9]  = '{"st_no_push",  1'b0, A_ST,                 64'h0,    64'h2};
    ops[10] = '{"ctrl_wr0",    1'b1, A_CTRL,               64'hFFFE, 64'h0};
    ops[11] = '{"ctrl_rd0",    1'b0, A_CTRL,               64'h0,    64'h0};

    repeat (3) @(negedge clk);
    check("reset txd", {63'b0, uart_txd}, 64'h1);
    check("reset rdata", bus_read_data, 64'h0);
    check("reset irq", {63'b0, tx_irq}, 64'h0);
    reset = 1'b1;

    foreach (ops[i]) begin
      if (ops[i].wr) bus_wr(ops[i].addr, ops[i].data);
      else begin
        bus_rw(ops[i].addr, 64'h0, 1'b0, rd);
        check(ops[i].nm, rd, ops[i].exp);
      end
    end

    // Single frame of 0x41
    bus_wr(A_TX, 64'h41);
    check("t1 txd before start", {63'b0, uart_txd}, 64'h1);
    chk_frames(24'h000041, 1, -1, "t1");
    bus_rw(A_ST, 64'h0, 1'b0, rd);
    check("t1 status idle", rd, 64'h2);

    // Three abutting frames
    bl = '{8'h55, 8'hAA, 8'h0F, 8'h0, 8'h0, 8'h0};
    bus_burst(A_TX, bl, 3);
    chk_frames(24'h0FAA55, 3, 1, "t2");
    bus_rw(A_ST, 64'h0, 1'b0, rd);
    check("t2 status empty", rd, 64'h2);

    // Overflow: six stores, one popped, four queued, one dropped
    bl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    bus_burst(A_TX, bl, 6);
    bus_rw(A_ST, 64'h8, 1'b1, rd);
    check("t3 status full+ovf", rd, 64'h40D);
    bus_rw(A_ST, 64'h0, 1'b0, rd);
    check("t3 ovf cleared", rd, 64'h405);
    repeat (600) @(negedge clk);
    bus_rw(A_ST, 64'h0, 1'b0, rd);
    check("t3 drained", rd, 64'h2);

    // TX-empty interrupt
    check("t4 irq masked", {63'b0, tx_irq}, 64'h0);
    bus_wr(A_CTRL, 64'h1);
    check("t4 irq idle", {63'b0, tx_irq}, 64'h1);
    bus_wr(A_TX, 64'h41);
    check("t4 irq queued", {63'b0, tx_irq}, 64'h0);
    for (int x = 0; x <= 100; x++) begin
      @(negedge clk);
      if (x == 50 || x == 99) check($sformatf("t4 irq frame x=%0d", x), {63'b0, tx_irq}, 64'h0);
      if (x == 100) check("t4 irq after stop", {63'b0, tx_irq}, 64'h1);
    end

    // Reset mid-frame
    bus_wr(A_TX, 64'h00);
    repeat (36) @(negedge clk);
    check("t5 txd mid-frame", {63'b0, uart_txd}, 64'h0);
    reset = 1'b0;
    #1;
    check("t5 txd in reset", {63'b0, uart_txd}, 64'h1);
    check("t5 rdata in reset", bus_read_data, 64'h0);
    check("t5 irq in reset", {63'b0, tx_irq}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    bus_rw(A_ST, 64'h0, 1'b0, rd);
    check("t5 status", rd, 64'h2);
    for (int i = 0; i < 12; i++) begin
      repeat (10) @(negedge clk);
      check($sformatf("t5 txd idle %0d", i), {63'b0, uart_txd}, 64'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
